vga_timing_gen: RTL

Parametrised VGA timing generator producing sync, pixel coordinates, visible-area flag and frame/line event strobes from the board clock. It generalises the fixed 640x480 generator: every timing field, sync polarity and the pixel-clock divider are parameters. It adds a run/freeze input, a pixel-enable strobe, line/frame/vblank event pulses and a frame counter. It sits between the board clock and the pixel/game renderers, which qualify their logic with `pixel_en_o`.

---
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: divided pixel tick, h/v scan counters, registered sync,
// coordinates, visible flag, line/frame/vblank event strobes and a wrapping frame counter.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter bit          HSYNC_POL   = 1'b0,
    parameter bit          VSYNC_POL   = 1'b0,
    parameter int unsigned X_W         = 10,
    parameter int unsigned Y_W         = 10,
    parameter int unsigned FRAME_CNT_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    output logic                   pixel_en_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic [X_W-1:0]         pixel_x_o,
    output logic [Y_W-1:0]         pixel_y_o,
    output logic                   visible_o,
    output logic                   line_start_o,
    output logic                   frame_start_o,
    output logic                   vblank_start_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
);
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);

    logic [DIV_W-1:0]       div_q, div_d;
    logic [X_W-1:0]         h_q, h_d;
    logic [Y_W-1:0]         v_q, v_d;
    logic                   started_q, started_d;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;

    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic           pix_en_q, hsync_q, vsync_q, vis_q, ls_q, fs_q, vb_q;

    logic [31:0] h_ext, v_ext;
    logic        tick, h_wrap, at_origin, hs_act, vs_act, vis;

    always_comb begin
        tick      = en_i && (div_q == DIV_LAST);
        h_ext     = 32'(h_q);
        v_ext     = 32'(v_q);
        h_wrap    = (h_q == H_LAST);
        at_origin = (h_q == '0) && (v_q == '0);
        hs_act    = (h_ext >= HS_START) && (h_ext < HS_END);
        vs_act    = (v_ext >= VS_START) && (v_ext < VS_END);
        vis       = (h_ext < H_VISIBLE) && (v_ext < V_VISIBLE);

        div_d     = div_q;
        h_d       = h_q;
        v_d       = v_q;
        started_d = started_q;
        fcnt_d    = fcnt_q;

        if (en_i) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end
        if (tick) begin
            started_d = 1'b1;
            // The origin after reset is frame 0; only a revisit of (0,0) counts a new frame.
            if (at_origin && started_q) begin
                fcnt_d = fcnt_q + FRAME_CNT_W'(1);
            end
            h_d = h_wrap ? '0 : h_q + X_W'(1);
            if (h_wrap) begin
                v_d = (v_q == V_LAST) ? '0 : v_q + Y_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q     <= '0;
            h_q       <= '0;
            v_q       <= '0;
            started_q <= 1'b0;
            fcnt_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            pix_en_q  <= 1'b0;
            hsync_q   <= ~HSYNC_POL;
            vsync_q   <= ~VSYNC_POL;
            vis_q     <= 1'b0;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
            vb_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            h_q       <= h_d;
            v_q       <= v_d;
            started_q <= started_d;
            fcnt_q    <= fcnt_d;
            pix_en_q  <= tick;
            ls_q      <= tick && (h_q == '0);
            fs_q      <= tick && at_origin;
            vb_q      <= tick && (h_q == '0) && (v_ext == V_VISIBLE);
            if (tick) begin
                x_q     <= h_q;
                y_q     <= v_q;
                vis_q   <= vis;
                hsync_q <= hs_act ? HSYNC_POL : ~HSYNC_POL;
                vsync_q <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            end
        end
    end

    assign pixel_en_o     = pix_en_q;
    assign hsync_o        = hsync_q;
    assign vsync_o        = vsync_q;
    assign pixel_x_o      = x_q;
    assign pixel_y_o      = y_q;
    assign visible_o      = vis_q;
    assign line_start_o   = ls_q;
    assign frame_start_o  = fs_q;
    assign vblank_start_o = vb_q;
    assign frame_cnt_o    = fcnt_q;

endmodule
